cpu_control_unit: RTL and testbench

Multi-cycle control unit for the 16-bit CPU: sequences fetch, decode and execute, and drives the control inputs of the program counter, instruction register, register file, ALU and RAM. It is the only source of `pc_ld`/`pc_inc` and guarantees they are never asserted together. It sits between the instruction register output and the integer datapath, and latches the ALU status flags used by conditional jumps.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/cu_decoder.sv | 116 +++++++++++
 rtl/cpu_control_unit.sv | 77 +++++++
 tb/tb_cpu_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: opcodes, ALU codes,
// control-unit state encodings and flag bit positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_INC  = 4'h7,
    OP_DEC  = 4'h8,
    OP_MOV  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_JMP  = 4'hC,
    OP_JZ   = 4'hD,
    OP_JC   = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  localparam logic [3:0] ALU_PASS_S = 4'h9;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EX_ALU    = 4'd3,
    ST_EX_LD     = 4'd4,
    ST_EX_ST     = 4'd5,
    ST_EX_JMP    = 4'd6,
    ST_HALT      = 4'd7,
    ST_WAIT_STEP = 4'd8
  } state_t;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/cu_decoder.sv
// Combinational state + opcode to control-word and next-state decoder.
// CU_SINGLE_STEP_EN adds step_req and the WAIT_STEP hold state.
module cu_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned RF_AW = 3
) (
  input  state_t           state,
  input  opcode_t          opcode,
  input  logic [RF_AW-1:0] rd,
  input  logic [RF_AW-1:0] rs,
  input  logic [RF_AW-1:0] rt,
  input  logic [2:0]       flags,
`ifdef CU_SINGLE_STEP_EN
  input  logic             step_req,
`endif
  output state_t           next_state,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             ir_ld,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             adr_sel,
  output logic             reg_w,
  output logic             w_sel,
  output logic [3:0]       alu_op,
  output logic [RF_AW-1:0] w_adr,
  output logic [RF_AW-1:0] r_adr,
  output logic [RF_AW-1:0] s_adr,
  output logic             flags_ld,
  output logic             halted
);

`ifdef CU_SINGLE_STEP_EN
  localparam state_t AFTER_EX = ST_WAIT_STEP;
`else
  localparam state_t AFTER_EX = ST_FETCH;
`endif

  always_comb begin
    next_state = ST_RESET;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    ir_ld      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    adr_sel    = 1'b0;
    reg_w      = 1'b0;
    w_sel      = 1'b0;
    alu_op     = '0;
    w_adr      = rd;
    r_adr      = rs;
    s_adr      = rt;
    flags_ld   = 1'b0;
    halted     = 1'b0;

    case (state)
      ST_RESET: next_state = ST_FETCH;
      ST_FETCH: begin
        mem_rd     = 1'b1;
        ir_ld      = 1'b1;
        pc_inc     = 1'b1;
        next_state = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode)
          OP_NOP:                    next_state = AFTER_EX;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_NOT, OP_INC, OP_DEC, OP_MOV: next_state = ST_EX_ALU;
          OP_LD:                     next_state = ST_EX_LD;
          OP_ST:                     next_state = ST_EX_ST;
          OP_JMP, OP_JZ, OP_JC:      next_state = ST_EX_JMP;
          OP_HALT:                   next_state = ST_HALT;
        endcase
      end
      ST_EX_ALU: begin
        alu_op     = opcode;
        reg_w      = 1'b1;
        flags_ld   = 1'b1;
        next_state = AFTER_EX;
      end
      ST_EX_LD: begin
        adr_sel    = 1'b1;
        mem_rd     = 1'b1;
        reg_w      = 1'b1;
        w_sel      = 1'b1;
        next_state = AFTER_EX;
      end
      ST_EX_ST: begin
        adr_sel    = 1'b1;
        s_adr      = rd;
        alu_op     = ALU_PASS_S;
        mem_wr     = 1'b1;
        next_state = AFTER_EX;
      end
      ST_EX_JMP: begin
        // Conditions use the latched flags only; live ALU status is ignored here.
        alu_op     = ALU_PASS_S;
        s_adr      = rs;
        pc_ld      = (opcode == OP_JMP) ||
                     (opcode == OP_JZ && flags[FLAG_Z]) ||
                     (opcode == OP_JC && flags[FLAG_C]);
        next_state = AFTER_EX;
      end
      ST_HALT: begin
        halted     = 1'b1;
        next_state = ST_HALT;
      end
`ifdef CU_SINGLE_STEP_EN
      ST_WAIT_STEP: next_state = step_req ? ST_FETCH : ST_WAIT_STEP;
`endif
      default: next_state = ST_RESET;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit: state and flags registers around cu_decoder.
// Define CU_SINGLE_STEP_EN to add the step_req single-step port.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned RF_AW = 3
) (
  input  logic             clk,
  input  logic             reset,
`ifdef CU_SINGLE_STEP_EN
  input  logic             step_req,
`endif
  input  logic [15:0]      ir,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             ir_ld,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             adr_sel,
  output logic             reg_w,
  output logic             w_sel,
  output logic [3:0]       alu_op,
  output logic [RF_AW-1:0] w_adr,
  output logic [RF_AW-1:0] r_adr,
  output logic [RF_AW-1:0] s_adr,
  output logic [2:0]       flags,
  output logic             halted,
  output logic [3:0]       state
);

  state_t state_q;
  state_t next_state;
  logic   flags_ld;

  cu_decoder #(.RF_AW(RF_AW)) u_dec (
    .state      (state_q),
    .opcode     (opcode_t'(ir[15:12])),
    .rd         (ir[9 +: RF_AW]),
    .rs         (ir[6 +: RF_AW]),
    .rt         (ir[3 +: RF_AW]),
    .flags      (flags),
`ifdef CU_SINGLE_STEP_EN
    .step_req   (step_req),
`endif
    .next_state (next_state),
    .pc_ld      (pc_ld),
    .pc_inc     (pc_inc),
    .ir_ld      (ir_ld),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .adr_sel    (adr_sel),
    .reg_w      (reg_w),
    .w_sel      (w_sel),
    .alu_op     (alu_op),
    .w_adr      (w_adr),
    .r_adr      (r_adr),
    .s_adr      (s_adr),
    .flags_ld   (flags_ld),
    .halted     (halted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      flags   <= '0;
    end else begin
      state_q <= next_state;
      if (flags_ld) flags <= {alu_n, alu_z, alu_c};
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized self-checking bench for cpu_control_unit against an
// instruction-level model of the expected per-cycle control words.
module tb_cpu_control_unit;
  import cpu_pkg::*;

  localparam int unsigned RF_AW = 3;

  // Control vector order: pc_ld pc_inc ir_ld mem_rd mem_wr adr_sel reg_w w_sel halted
  localparam logic [8:0] C_NONE  = 9'b000000000;
  localparam logic [8:0] C_FETCH = 9'b011100000;
  localparam logic [8:0] C_ALU   = 9'b000000100;
  localparam logic [8:0] C_LD    = 9'b000101110;
  localparam logic [8:0] C_ST    = 9'b000011000;
  localparam logic [8:0] C_JMP   = 9'b100000000;
  localparam logic [8:0] C_HALT  = 9'b000000001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] ir = '0;
  logic alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0;
`ifdef CU_SINGLE_STEP_EN
  logic step_req = 1'b0;
`endif
  logic pc_ld, pc_inc, ir_ld, mem_rd, mem_wr, adr_sel, reg_w, w_sel, halted;
  logic [3:0] alu_op, state;
  logic [RF_AW-1:0] w_adr, r_adr, s_adr;
  logic [2:0] flags;

  int total = 0;
  int bad = 0;
  logic [2:0] mflags = '0;

  cpu_control_unit #(.RF_AW(RF_AW)) dut (
    .clk(clk), .reset(reset),
`ifdef CU_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .ir(ir), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .adr_sel(adr_sel), .reg_w(reg_w), .w_sel(w_sel), .alu_op(alu_op),
    .w_adr(w_adr), .r_adr(r_adr), .s_adr(s_adr), .flags(flags),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_alu;
    {alu_n, alu_z, alu_c} = 3'($urandom_range(0, 7));
  endtask

  task automatic expect_cycle(input string tag, input state_t st, input logic [8:0] c,
                              input logic [3:0] op);
    #1;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".ctl"}, 32'({pc_ld, pc_inc, ir_ld, mem_rd, mem_wr, adr_sel, reg_w, w_sel, halted}),
          32'(c));
    check({tag, ".aluop"}, 32'(alu_op), 32'(op));
    check({tag, ".flags"}, 32'(flags), 32'(mflags));
  endtask

  task automatic step_wait;
`ifdef CU_SINGLE_STEP_EN
    int unsigned n;
    n = $urandom_range(0, 2);
    for (int unsigned i = 0; i < n; i++) begin
      rand_alu();
      expect_cycle("wait", ST_WAIT_STEP, C_NONE, 4'h0);
      tick();
    end
    step_req = 1'b1;
    rand_alu();
    expect_cycle("wait_go", ST_WAIT_STEP, C_NONE, 4'h0);
    tick();
    step_req = 1'b0;
`endif
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    mflags = '0;
    rand_alu();
    expect_cycle("rst", ST_RESET, C_NONE, 4'h0);
    tick();
    reset = 1'b0;
    expect_cycle("rst_rel", ST_RESET, C_NONE, 4'h0);
    tick();
  endtask

  // Walks one instruction from FETCH; nzc >= 0 forces ALU status in EX.
  task automatic run_instr(input logic [15:0] instr, input int nzc, input bit rst_mid);
    logic [3:0] op;
    logic [2:0] rd, rs, rt;
    logic [2:0] live;
    bit taken;
    op = instr[15:12];
    rd = instr[11:9];
    rs = instr[8:6];
    rt = instr[5:3];
    ir = instr;
    rand_alu();
    expect_cycle("fetch", ST_FETCH, C_FETCH, 4'h0);
    tick();
    rand_alu();
    expect_cycle("decode", ST_DECODE, C_NONE, 4'h0);
    check("decode.adr", 32'({w_adr, r_adr, s_adr}), 32'({rd, rs, rt}));
    tick();
    if (op == 4'h0) begin
      step_wait();
      return;
    end
    if (op == 4'hF) begin
      for (int unsigned i = 0; i < 4; i++) begin
        rand_alu();
        expect_cycle("halt", ST_HALT, C_HALT, 4'h0);
        tick();
      end
      return;
    end
    if (nzc >= 0) {alu_n, alu_z, alu_c} = 3'(nzc);
    else rand_alu();
    live = {alu_n, alu_z, alu_c};
    if (op <= 4'h9) begin
      expect_cycle("ex_alu", ST_EX_ALU, C_ALU, op);
      check("ex_alu.adr", 32'({w_adr, r_adr, s_adr}), 32'({rd, rs, rt}));
    end else if (op == 4'hA) begin
      expect_cycle("ex_ld", ST_EX_LD, C_LD, 4'h0);
      check("ex_ld.wadr", 32'(w_adr), 32'(rd));
    end else if (op == 4'hB) begin
      expect_cycle("ex_st", ST_EX_ST, C_ST, 4'h9);
      check("ex_st.sadr", 32'(s_adr), 32'(rd));
    end else begin
      taken = (op == 4'hC) || (op == 4'hD && mflags[1]) || (op == 4'hE && mflags[0]);
      expect_cycle("ex_jmp", ST_EX_JMP, taken ? C_JMP : C_NONE, 4'h9);
      check("ex_jmp.sadr", 32'(s_adr), 32'(rs));
    end
    if (rst_mid) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mflags = '0;
      expect_cycle("rst_mid", ST_RESET, C_NONE, 4'h0);
      tick();
      return;
    end
    tick();
    if (op <= 4'h9) mflags = live;
    step_wait();
  endtask

  initial begin
    logic [15:0] instr;
    do_reset();
    run_instr(16'h1290, 3'b010, 1'b0);
    run_instr(16'hA940, -1, 1'b0);
    run_instr(16'hB680, -1, 1'b0);
    run_instr(16'h2498, 3'b010, 1'b0);
    run_instr(16'hD200, 3'b101, 1'b0);
    run_instr(16'h3498, 3'b101, 1'b0);
    run_instr(16'hD200, 3'b010, 1'b0);
    run_instr(16'hE040, -1, 1'b0);
    run_instr(16'hC1C0, -1, 1'b0);
    run_instr(16'h0000, -1, 1'b0);
    run_instr(16'hB540, -1, 1'b1);
    for (int unsigned i = 0; i < 300; i++) begin
      instr = 16'($urandom);
      instr[15:12] = 4'($urandom_range(0, 14));
      run_instr(instr, -1, 1'b0);
    end
    run_instr(16'hF000, -1, 1'b0);
    do_reset();
    run_instr(16'h7FF8, 3'b111, 1'b0);
    run_instr(16'hE000, -1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
